// File: rtl/tx_whitening_bluetooth_ble.sv
// BLE transmit data whitening: XORs the serial HEC-stage bit stream with the
// x^7 + x^4 + 1 whitening sequence seeded from the RF channel index.
module tx_whitening_bluetooth_ble #(
    parameter int CNT_W  = 14,
    parameter int LFSR_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             whiten_en,
    input  logic [5:0]       channel_index,
    input  logic [CNT_W-1:0] num_bits,
    input  logic             valid_in,
    input  logic             data_in,
    output logic             data_out,
    output logic             valid_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LFSR_W-1:0]   lfsr;
    logic [CNT_W-1:0]    len;
    logic                bypass;
    logic                data_p1;
    logic                vld_p1;
    logic [CNT_W-1:0]    cnt_inc;

    // Position 0 is forced to 1 so the register can never lock up at zero.
    function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [5:0] ch);
        logic [LFSR_W-1:0] s;
        s[0] = 1'b1;
        for (int i = 1; i < LFSR_W; i++) s[i] = ch[6-i];
        return s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        logic [LFSR_W-1:0] s;
        s[0] = l[6];
        s[1] = l[0];
        s[2] = l[1];
        s[3] = l[2];
        s[4] = l[3] ^ l[6];
        s[5] = l[4];
        s[6] = l[5];
        return s;
    endfunction

    function automatic logic whiten_bit(input logic d, input logic [LFSR_W-1:0] l,
                                        input logic byp);
        return d ^ (~byp & l[6]);
    endfunction

    assign cnt_inc = bit_count + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (num_bits == '0) ? DONE : RUN;
            RUN:  if (valid_in && (cnt_inc == len)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Stage p1: whitened bit registered one cycle after its input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr      <= '0;
            len       <= '0;
            bypass    <= 1'b0;
            bit_count <= '0;
            data_p1   <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr      <= lfsr_seed(channel_index);
                        len       <= num_bits;
                        bypass    <= ~whiten_en;
                        bit_count <= '0;
                    end
                end
                RUN: begin
                    if (valid_in) begin
                        data_p1 <= whiten_bit(data_in, lfsr, bypass);
                        vld_p1  <= 1'b1;
                        if (!bypass) lfsr <= lfsr_step(lfsr);
                        if (bit_count != len) bit_count <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out  = data_p1;
    assign valid_out = vld_p1;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_tx_whitening_bluetooth_ble.sv
// Directed bench for tx_whitening_bluetooth_ble using hand-derived whitening bits.
module tb_tx_whitening_bluetooth_ble;

    localparam int CNT_W = 14;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             whiten_en;
    logic [5:0]       channel_index;
    logic [CNT_W-1:0] num_bits;
    logic             valid_in;
    logic             data_in;
    logic             data_out;
    logic             valid_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bit_count;

    int checks = 0;
    int errors = 0;

    // Channel 37 whitening bits 1..5
    logic exp_w [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    tx_whitening_bluetooth_ble #(.CNT_W(CNT_W), .LFSR_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .whiten_en(whiten_en),
        .channel_index(channel_index), .num_bits(num_bits), .valid_in(valid_in),
        .data_in(data_in), .data_out(data_out), .valid_out(valid_out),
        .busy(busy), .done(done), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [5:0] ch, input logic wen, input logic [CNT_W-1:0] n,
                       input logic v);
        start         = 1'b1;
        channel_index = ch;
        whiten_en     = wen;
        num_bits      = n;
        valid_in      = v;
        data_in       = 1'b0;
        tick();
        start    = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic send(input logic v, input logic d);
        valid_in = v;
        data_in  = d;
        tick();
        valid_in = 1'b0;
    endtask

    initial begin
        int k;
        logic early;
        logic [5:0] pat;
        reset = 1'b1; start = 1'b0; whiten_en = 1'b0; channel_index = '0;
        num_bits = '0; valid_in = 1'b0; data_in = 1'b0;
        #3;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bit_count", bit_count, 0);
        tick();
        reset = 1'b0;

        // valid_in while idle and unarmed produces nothing
        send(1'b1, 1'b1);
        chk("idle_valid_out", valid_out, 0);

        // Test 1: whitened frame, channel 37, three zero bits
        arm(6'd37, 1'b1, 14'd3, 1'b0);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0);
            chk($sformatf("t1_vld%0d", i), valid_out, 1);
            chk($sformatf("t1_data%0d", i), data_out, exp_w[i]);
            chk($sformatf("t1_cnt%0d", i), bit_count, i + 1);
            chk($sformatf("t1_done%0d", i), done, (i == 2) ? 1 : 0);
        end
        chk("t1_busy_after", busy, 0);
        send(1'b0, 1'b0);
        chk("t1_done_clear", done, 0);
        chk("t1_vld_clear", valid_out, 0);
        chk("t1_cnt_hold", bit_count, 3);

        // Test 2: bypass passes data unmodified, LFSR frozen at seed
        arm(6'd37, 1'b0, 14'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, (i != 1));
            chk($sformatf("t2_data%0d", i), data_out, (i != 1) ? 1 : 0);
        end
        chk("t2_done", done, 1);
        chk("t2_lfsr", dut.lfsr, 7'b1010011);
        send(1'b0, 1'b0);

        // Test 3: gaps between valid bits
        pat = 6'b101001;  // bit0 first: 1,0,0,1,0,1
        k = 0;
        arm(6'd37, 1'b1, 14'd3, 1'b0);
        for (int j = 0; j < 6; j++) begin
            send(pat[j], 1'b0);
            if (pat[j]) begin
                chk($sformatf("t3_vld%0d", j), valid_out, 1);
                chk($sformatf("t3_data%0d", j), data_out, exp_w[k]);
                k++;
            end else begin
                chk($sformatf("t3_gapvld%0d", j), valid_out, 0);
            end
            chk($sformatf("t3_cnt%0d", j), bit_count, k);
        end
        chk("t3_done", done, 1);
        send(1'b0, 1'b0);

        // Test 4: zero-length frame
        arm(6'd5, 1'b1, 14'd0, 1'b0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_vld", valid_out, 0);
        chk("t4_cnt", bit_count, 0);
        send(1'b0, 1'b0);
        chk("t4_done_once", done, 0);
        chk("t4_vld_after", valid_out, 0);

        // Test 5: reset mid-frame, then replay from the seed
        arm(6'd37, 1'b1, 14'd5, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        chk("t5_cnt_before", bit_count, 2);
        chk("t5_vld_before", valid_out, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_vld", valid_out, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cnt", bit_count, 0);
        chk("t5_rst_data", data_out, 0);
        tick();
        chk("t5_rst_done", done, 0);
        reset = 1'b0;
        tick();
        chk("t5_no_done", done, 0);
        arm(6'd37, 1'b1, 14'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 1'b0);
            chk($sformatf("t5_data%0d", i), data_out, exp_w[i]);
        end
        chk("t5_done", done, 1);
        chk("t5_cnt", bit_count, 5);
        send(1'b0, 1'b0);

        // Test 6: start+valid in IDLE drops the bit; start in RUN is ignored
        arm(6'd37, 1'b1, 14'd3, 1'b1);
        chk("t6_drop_vld", valid_out, 0);
        chk("t6_drop_cnt", bit_count, 0);
        send(1'b1, 1'b0);
        chk("t6_data0", data_out, exp_w[0]);
        start = 1'b1; channel_index = 6'd0; num_bits = 14'd7;
        send(1'b1, 1'b0);
        start = 1'b0;
        chk("t6_data1", data_out, exp_w[1]);
        chk("t6_cnt1", bit_count, 2);
        send(1'b1, 1'b0);
        chk("t6_data2", data_out, exp_w[2]);
        chk("t6_done", done, 1);
        send(1'b1, 1'b1);
        chk("t6_extra_vld", valid_out, 0);
        chk("t6_extra_cnt", bit_count, 3);
        send(1'b1, 1'b1);
        chk("t6_extra2_cnt", bit_count, 3);
        chk("t6_extra2_vld", valid_out, 0);

        // Test 7: maximum frame length completes without wrap
        arm(6'd37, 1'b0, 14'h3FFF, 1'b0);
        early = 1'b0;
        for (int i = 1; i < 16383; i++) begin
            send(1'b1, i[0]);
            if (done || !busy || (bit_count != i[CNT_W-1:0])) early = 1'b1;
        end
        chk("t7_progress", early, 0);
        send(1'b1, 1'b1);
        chk("t7_done", done, 1);
        chk("t7_cnt", bit_count, 14'h3FFF);
        chk("t7_data", data_out, 1);
        send(1'b1, 1'b0);
        chk("t7_cnt_hold", bit_count, 14'h3FFF);
        chk("t7_done_clear", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_whitening_bluetooth_ble.md
Name: tx_whitening_bluetooth_ble

Overview:
Serial data-whitening stage that sits directly downstream of the header-HEC stage in the BLE PHY transmit chain. It consumes the HEC stage's serial bit stream (data_out/valid_out) and its bit count (num_after_hec). Each bit is XORed with the BLE whitening sequence from a 7-bit LFSR (x^7 + x^4 + 1) seeded from the RF channel index. The whitened bits are forwarded to the modulator path. Per-frame sequencing is handled by a start/run/done state machine and a bit counter.

Parameters:
CNT_W, 14, width of frame-length and bit counters (matches num_after_hec)
LFSR_W, 7, whitening LFSR width; fixed by standard, not to be overridden

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; arms a new frame (loads seed, captures num_bits)
whiten_en  input  1  1 = whiten, 0 = bypass (data passes unmodified, LFSR frozen); sampled at start
channel_index  input  6  RF channel index 0..39, seeds LFSR; sampled at start
num_bits  input  CNT_W  bits in the frame (from HEC stage num_after_hec); sampled at start
valid_in  input  1  data_in is a valid bit this cycle
data_in  input  1  serial bit from HEC stage
data_out  output  1  whitened bit, registered
valid_out  output  1  data_out valid, registered
busy  output  1  high in RUN
done  output  1  one-cycle pulse when the last frame bit has been emitted
bit_count  output  CNT_W  bits processed in current/last frame

Behaviour:
- Reset (async, any state): state=IDLE; lfsr=7'b0; data_out=0; valid_out=0; busy=0; done=0; bit_count=0; captured len=0; captured bypass=0.
- LFSR bit numbering follows standard positions 0..6.
  - Seed at start: lfsr[0]=1; lfsr[1..6] = channel_index[5..0], so lfsr[1]=ch[5] and lfsr[6]=ch[0].
  - Whitening bit w = lfsr[6].
  - Advance step: lfsr[0]<=lfsr[6]; lfsr[4]<=lfsr[3]^lfsr[6]; every other position lfsr[n]<=lfsr[n-1].
- FSM states: IDLE, RUN, DONE.
  - IDLE: valid_in ignored (valid_out stays 0). On start: load seed, len<=num_bits, bypass<=~whiten_en, bit_count<=0. Go to RUN if num_bits!=0, else DONE.
  - RUN: busy=1. On each valid_in cycle:
    - data_out<=data_in^(bypass?0:w); valid_out<=1 (latency exactly 1 cycle);
    - lfsr advances only when bypass=0; bit_count<=bit_count+1.
    - If bit_count+1==len, go to DONE on the same edge.
    - Cycles without valid_in: valid_out<=0, and lfsr and bit_count hold. Gaps of any length are legal.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE. valid_out is 1 on the DONE cycle (last bit) unless num_bits was 0.
- Simultaneous events:
  - start in RUN or DONE: ignored; the frame is not restarted.
  - start and valid_in together in IDLE: start is taken and that bit is dropped. The upstream stage must not assert valid before arming.
  - valid_in in DONE: bit dropped, bit_count unchanged.
- Width rules:
  - bit_count saturates at len.
  - num_bits=2^CNT_W-1 must complete without wrap.
- bit_count holds its final value after DONE until the next start.
- Reset mid-frame: all outputs clear immediately (async); no done pulse is produced for the aborted frame.

Test Plan:
- Reset then start with channel_index=37 (6'b100101), whiten_en=1, num_bits=3, data_in=0 on 3 consecutive valid cycles -> data_out=1,0,1, each 1 cycle after its input; done pulses on the cycle of the 3rd output; bit_count=3; busy low afterwards.
- Same frame with whiten_en=0, data_in=1,0,1 -> data_out=1,0,1 unmodified; lfsr unchanged from seed 7'b1010011 (bit6..bit0).
- Channel 37, num_bits=3, valid_in pattern 1,0,0,1,0,1 -> outputs identical to test 1 with gaps mirrored; bit_count holds during gaps.
- start with num_bits=0 -> DONE on the next cycle, done pulses once, valid_out never asserts.
- Assert reset after 2 of 5 bits -> all outputs 0 immediately, no done. A fresh start then replays the seed sequence from bit 1.
- start pulse during RUN plus extra valid_in after done -> frame continues unaffected, extra bits dropped, bit_count=num_bits.
